// File: rtl/pc_fetch_unit_pkg.sv
// pc_fetch_unit_pkg: shared RISC-V fetch definitions (riscv_defs) for the PC/fetch slice.
package pc_fetch_unit_pkg;
  localparam int PC_W = 6;
  localparam int INSTR_W = 32;
  localparam logic [PC_W-1:0] RESET_PC = '0;
  localparam logic [INSTR_W-1:0] NOP = 32'h0000_0013;
  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/pc_fetch_unit_if.sv
// pc_fetch_unit_if: PC/imem, redirect and decode-handshake signals of the fetch stage.
interface pc_fetch_unit_if import pc_fetch_unit_pkg::*; ();
  logic [PC_W-1:0]    pc_o;
  logic [PC_W-1:0]    pc_seq_i;
  logic               imem_en_o;
  logic [INSTR_W-1:0] imem_rdata_i;
  logic               redirect_valid_i;
  logic [PC_W-1:0]    redirect_pc_i;
  logic               if_valid_o;
  logic               if_ready_i;
  logic [PC_W-1:0]    if_pc_o;
  logic [INSTR_W-1:0] if_instr_o;
  modport master (
    output pc_o, imem_en_o, if_valid_o, if_pc_o, if_instr_o,
    input  pc_seq_i, imem_rdata_i, redirect_valid_i, redirect_pc_i, if_ready_i
  );
  modport slave (
    input  pc_o, imem_en_o, if_valid_o, if_pc_o, if_instr_o,
    output pc_seq_i, imem_rdata_i, redirect_valid_i, redirect_pc_i, if_ready_i
  );
endinterface

// File: rtl/pc_fetch_unit_fifo.sv
// fetch_skid_fifo: 2-entry {pc, instr} buffer; head reads as zero when empty.
module fetch_skid_fifo import pc_fetch_unit_pkg::*; (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output logic [1:0]   count,
  output fetch_entry_t head
);
  fetch_entry_t mem [2];
  logic rd;
  logic wr;
  assign wr = rd ^ count[0];
  assign head = (count != 2'd0) ? mem[rd] : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 2'd0;
      rd <= 1'b0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      count <= 2'(count + {1'b0, push} - {1'b0, pop});
      rd <= rd ^ pop;
    end
  end
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr] <= din;
  end
  assert property (@(posedge clk) disable iff (!rst_n) !(push && count == 2'd2));
endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC register, one-deep imem read tracking and credit-based issue into the skid FIFO.
module pc_fetch_unit import pc_fetch_unit_pkg::*; (
  input logic             clk,
  input logic             rst_n,
  pc_fetch_unit_if.master bus
);
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] inflight_pc_q;
  logic            inflight_q;
  logic            pop;
  logic            push;
  logic            issue;
  logic [1:0]      count;
  logic [2:0]      occ;
  fetch_entry_t    head;
  assign bus.pc_o = pc_q;
  assign bus.if_valid_o = (count != 2'd0) & ~bus.redirect_valid_i;
  assign bus.if_pc_o = head.pc;
  assign bus.if_instr_o = head.instr;
  assign pop = bus.if_valid_o & bus.if_ready_i;
  // Buffered plus in-flight entries never exceed the FIFO depth.
  assign occ = 3'({1'b0, count} + {2'b0, inflight_q} - {2'b0, pop});
  assign issue = rst_n & ~bus.redirect_valid_i & (occ < 3'd2);
  assign bus.imem_en_o = issue;
  assign push = inflight_q & ~bus.redirect_valid_i;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
      inflight_q <= 1'b0;
      inflight_pc_q <= '0;
    end else if (bus.redirect_valid_i) begin
      pc_q <= bus.redirect_pc_i;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        inflight_pc_q <= pc_q;
        pc_q <= bus.pc_seq_i;
      end
    end
  end
  fetch_skid_fifo u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (bus.redirect_valid_i),
    .din   ({inflight_pc_q, bus.imem_rdata_i}),
    .count (count),
    .head  (head)
  );
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed cycle-by-cycle vectors for the fetch stage with a 1-cycle imem model.
module tb_pc_fetch_unit;
  import pc_fetch_unit_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vectors = 0;
  int errs = 0;
  pc_fetch_unit_if bus ();
  pc_fetch_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  assign bus.pc_seq_i = PC_W'(bus.pc_o + 1'b1);
  always @(posedge clk) if (bus.imem_en_o) bus.imem_rdata_i <= 32'hA000_0000 | {26'b0, bus.pc_o};
  task automatic drive(input logic rs, input logic r, input logic rv, input logic [5:0] rp);
    @(negedge clk);
    rst_n = rs;
    bus.if_ready_i = r;
    bus.redirect_valid_i = rv;
    bus.redirect_pc_i = rp;
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic expect_cyc(input string tag, input logic en, input logic [5:0] pc, input logic v, input logic [5:0] ipc);
    chk({tag, ".en"}, {31'b0, bus.imem_en_o}, {31'b0, en});
    chk({tag, ".pc"}, {26'b0, bus.pc_o}, {26'b0, pc});
    chk({tag, ".valid"}, {31'b0, bus.if_valid_o}, {31'b0, v});
    if (v) begin
      chk({tag, ".if_pc"}, {26'b0, bus.if_pc_o}, {26'b0, ipc});
      chk({tag, ".instr"}, bus.if_instr_o, 32'hA000_0000 | {26'b0, ipc});
    end
  endtask
  initial begin
    bus.if_ready_i = 1'b1;
    bus.redirect_valid_i = 1'b0;
    bus.redirect_pc_i = '0;
    drive(0, 1, 0, 0);
    expect_cyc("rst", 0, 0, 0, 0);
    chk("rst.if_pc", {26'b0, bus.if_pc_o}, 32'd0);
    chk("rst.instr", bus.if_instr_o, 32'd0);
    drive(1, 1, 0, 0); expect_cyc("s1.c0", 1, 0, 0, 0);
    drive(1, 1, 0, 0); expect_cyc("s1.c1", 1, 1, 0, 0);
    drive(1, 1, 0, 0); expect_cyc("s1.c2", 1, 2, 1, 0);
    drive(1, 0, 0, 0); expect_cyc("s2.c3", 0, 3, 1, 1);
    for (int i = 4; i <= 8; i++) begin
      drive(1, 0, 0, 0); expect_cyc($sformatf("s2.c%0d", i), 0, 3, 1, 1);
    end
    drive(1, 1, 0, 0); expect_cyc("s2.c9", 1, 3, 1, 1);
    drive(1, 1, 0, 0); expect_cyc("s2.c10", 1, 4, 1, 2);
    drive(1, 1, 0, 0); expect_cyc("s2.c11", 1, 5, 1, 3);
    drive(1, 1, 0, 0); expect_cyc("s2.c12", 1, 6, 1, 4);
    drive(1, 0, 1, 6'h20); expect_cyc("s3.redir", 0, 7, 0, 0);
    drive(1, 1, 0, 0); expect_cyc("s3.c1", 1, 6'h20, 0, 0);
    drive(1, 1, 0, 0); expect_cyc("s3.c2", 1, 6'h21, 0, 0);
    drive(1, 1, 0, 0); expect_cyc("s3.c3", 1, 6'h22, 1, 6'h20);
    drive(1, 1, 0, 0); expect_cyc("s3.c4", 1, 6'h23, 1, 6'h21);
    drive(1, 1, 1, 6'd62); expect_cyc("s4.redir", 0, 6'h24, 0, 0);
    drive(1, 1, 0, 0); expect_cyc("s4.c1", 1, 62, 0, 0);
    drive(1, 1, 0, 0); expect_cyc("s4.c2", 1, 63, 0, 0);
    drive(1, 1, 0, 0); expect_cyc("s4.c3", 1, 0, 1, 62);
    drive(1, 1, 0, 0); expect_cyc("s4.c4", 1, 1, 1, 63);
    drive(1, 1, 0, 0); expect_cyc("s4.c5", 1, 2, 1, 0);
    drive(1, 1, 0, 0); expect_cyc("s4.c6", 1, 3, 1, 1);
    drive(1, 1, 1, 6'h10); expect_cyc("s5.redir1", 0, 4, 0, 0);
    drive(1, 1, 1, 6'h30); expect_cyc("s5.redir2", 0, 6'h10, 0, 0);
    drive(1, 1, 0, 0); expect_cyc("s5.c1", 1, 6'h30, 0, 0);
    drive(1, 1, 0, 0); expect_cyc("s5.c2", 1, 6'h31, 0, 0);
    drive(1, 1, 0, 0); expect_cyc("s5.c3", 1, 6'h32, 1, 6'h30);
    drive(1, 1, 0, 0); expect_cyc("s5.c4", 1, 6'h33, 1, 6'h31);
    drive(0, 1, 0, 0); expect_cyc("s6.rst", 0, 0, 0, 0);
    chk("s6.rst.if_pc", {26'b0, bus.if_pc_o}, 32'd0);
    drive(1, 1, 0, 0); expect_cyc("s6.c0", 1, 0, 0, 0);
    drive(1, 1, 0, 0); expect_cyc("s6.c1", 1, 1, 0, 0);
    drive(1, 1, 0, 0); expect_cyc("s6.c2", 1, 2, 1, 0);
    drive(1, 1, 0, 0); expect_cyc("s6.c3", 1, 3, 1, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
